// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller.
//   - op_e        : 3-bit command operation codes (cmd_op[2:0])
//   - ALU_*       : one-hot ALU opcode constants
//   - state_e     : sequencer FSM states
//   - CLR_HOLD    : number of cycles alu_rst is held for a CLR command
//   - alu_ctrl_t  : bundle of ALU control lines
//   - decode_op() : translate an operation code into ALU controls
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOT = 3'd7
  } op_e;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_CAPTURE,
    S_DONE,
    S_CLEAR
  } state_e;

  localparam int unsigned CLR_HOLD = 2;

  typedef struct packed {
    logic [4:0] opcode;
    logic       inv;
    logic       sub;
    logic       ovwa;
  } alu_ctrl_t;

  function automatic alu_ctrl_t decode_op(input op_e op, input logic ld_a);
    alu_ctrl_t c;
    c = '0;
    case (op)
      OP_ADD: c.opcode = ALU_ADD;
      OP_SUB: begin
        c.opcode = ALU_ADD;
        c.sub    = 1'b1;
      end
      OP_MUL: c.opcode = ALU_MUL;
      OP_AND: c.opcode = ALU_AND;
      OP_OR:  c.opcode = ALU_OR;
      OP_XOR: c.opcode = ALU_XOR;
      OP_NOT: begin
        c.opcode = ALU_XOR;
        c.inv    = 1'b1;
      end
      default: c = '0;
    endcase
    c.ovwa = (op != OP_NOP) && ld_a;
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO for encoded ALU commands.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write request and data (ignored while full)
//   pop_i/rdata_o : read request and head-of-queue data (ignored while empty)
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [DW-1:0]          wdata_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // full is evaluated on the current count, so a same-cycle pop never frees a slot early
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command sequencer in front of the ALU with a result capture
// stage behind it.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake; cmd_op = {ld_a, op[2:0]}
//   cmd_a, cmd_b             : operands
//   alu_in1/in2, alu_opcode,
//   alu_inv/sub/ovwA, alu_rst: registered ALU controls
//   alu_out, alu_zero/of/neg : ALU result and flags
//   res_valid/res_ready      : result handshake
//   res_data, res_zero/of/neg: captured result and flags
//   busy, fifo_count         : status
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  output logic [WIDTH-1:0]       alu_in1,
  output logic [WIDTH-1:0]       alu_in2,
  output logic [4:0]             alu_opcode,
  output logic                   alu_inv,
  output logic                   alu_sub,
  output logic                   alu_ovwA,
  output logic                   alu_rst,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_zero,
  input  logic                   alu_of,
  input  logic                   alu_neg,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic                   res_zero,
  output logic                   res_of,
  output logic                   res_neg,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CMD_W = 4 + 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + CLR_HOLD) + 1;

  // command FIFO
  logic             fifo_full, fifo_empty, pop;
  logic [CMD_W-1:0] head;
  logic             head_ld;
  op_e              head_op;
  logic [WIDTH-1:0] head_a, head_b;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (CMD_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_ld = head[CMD_W-1];
  assign head_op = op_e'(head[CMD_W-2 -: 3]);
  assign head_a  = head[2*WIDTH-1 -: WIDTH];
  assign head_b  = head[WIDTH-1:0];

  // sequencer state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_ctrl_t        ctrl_q, ctrl_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic             alu_rst_q, alu_rst_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_of_q, res_of_d;
  logic             res_neg_q, res_neg_d;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      alu_rst_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_of_q    <= 1'b0;
      res_neg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      alu_rst_q   <= alu_rst_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_of_q    <= res_of_d;
      res_neg_q   <= res_neg_d;
    end
  end

  // next-state logic; cnt_q counts execute cycles in EXEC and remaining hold
  // cycles in CLEAR
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_op == OP_NOP) begin
            if (head_ld) begin
              state_d = S_CLEAR;
              cnt_d   = CNT_W'(CLR_HOLD - 1);
            end
          end else begin
            state_d = S_EXEC;
            cnt_d   = (head_op == OP_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(1);
          end
        end
      end
      S_EXEC: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_CAPTURE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: state_d = S_DONE;
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // output logic: ALU controls are registered from the next state so they
  // change on the same edge as the state transition
  always_comb begin
    ctrl_d      = ctrl_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    alu_rst_d   = (state_d == S_CLEAR);
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_of_d    = res_of_q;
    res_neg_d   = res_neg_q;

    if (state_q == S_IDLE && pop && head_op != OP_NOP) begin
      ctrl_d = decode_op(head_op, head_ld);
      in1_d  = head_a;
      in2_d  = head_b;
    end else if (state_d != S_EXEC) begin
      ctrl_d = '0;
    end

    if (state_q == S_CAPTURE) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out;
      res_zero_d  = alu_zero;
      res_of_d    = alu_of;
      res_neg_d   = alu_neg;
    end else if (state_q == S_DONE && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_opcode = ctrl_q.opcode;
  assign alu_inv    = ctrl_q.inv;
  assign alu_sub    = ctrl_q.sub;
  assign alu_ovwA   = ctrl_q.ovwa;
  assign alu_rst    = alu_rst_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_zero   = res_zero_q;
  assign res_of     = res_of_q;
  assign res_neg    = res_neg_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned WIDTH      = 16;
  localparam int unsigned MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic [15:0] alu_in1, alu_in2;
  logic [4:0]  alu_opcode;
  logic        alu_inv, alu_sub, alu_ovwA, alu_rst;
  logic [15:0] alu_out;
  logic        alu_zero, alu_of, alu_neg;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_zero, res_of, res_neg;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_exp    = 0;
  int n_seen   = 0;
  int alu_rst_cycles = 0;
  logic [18:0] sb_q[$];   // {zero, of, neg, data}

  alu_issue_ctrl #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_inv    (alu_inv),
    .alu_sub    (alu_sub),
    .alu_ovwA   (alu_ovwA),
    .alu_rst    (alu_rst),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_of     (alu_of),
    .alu_neg    (alu_neg),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_of     (res_of),
    .res_neg    (res_neg),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Registered ALU driven by the one-hot controls
  function automatic logic [16:0] alu_fn(input logic [4:0] opc, input logic inv,
                                         input logic sub, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic [31:0] p;
    logic        of;
    r  = '0;
    of = 1'b0;
    p  = 32'(a) * 32'(b);
    case (opc)
      5'b00001: begin
        r  = sub ? a - b : a + b;
        of = sub ? ((a[15] != b[15]) && (r[15] != a[15]))
                 : ((a[15] == b[15]) && (r[15] != a[15]));
      end
      5'b00010: begin
        r  = p[15:0];
        of = |p[31:16];
      end
      5'b00100: r = a & b;
      5'b01000: r = a | b;
      5'b10000: r = inv ? ~(a ^ b) : (a ^ b);
      default:  r = '0;
    endcase
    return {of, r};
  endfunction

  logic [15:0] m_out;
  logic        m_of;
  always @(posedge clk) begin
    if (alu_rst) begin
      m_out <= '0;
      m_of  <= 1'b0;
    end else if (alu_opcode != 5'b0) begin
      {m_of, m_out} <= alu_fn(alu_opcode, alu_inv, alu_sub, alu_in1, alu_in2);
    end
  end
  assign alu_out  = m_out;
  assign alu_of   = m_of;
  assign alu_zero = (m_out == 16'h0);
  assign alu_neg  = m_out[15];

  // Expected result straight from the command encoding
  function automatic logic [18:0] exp_result(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [15:0] r;
    logic [31:0] p;
    logic        of;
    of = 1'b0;
    p  = 32'(a) * 32'(b);
    case (op)
      3'd1: begin r = a + b; of = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd2: begin r = a - b; of = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd3: begin r = p[15:0]; of = |p[31:16]; end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      3'd7: r = ~(a ^ b);
      default: r = '0;
    endcase
    return {(r == 16'h0), of, r[15], r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned w;
    w = 0;
    while (!cmd_ready && w < 60) begin
      tick();
      w++;
    end
    check("push_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    if (op[2:0] != 3'd0) begin
      sb_q.push_back(exp_result(op[2:0], a, b));
      n_exp++;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned w;
    w = 0;
    while ((busy || res_valid) && w < 200) begin
      tick();
      w++;
    end
    check("wait_idle", 32'(busy || res_valid), 0);
  endtask

  // Scoreboard: a result is consumed on the edge following a negedge where
  // valid and ready are both high
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst && res_valid && res_ready) begin
      check("sb_pending", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("res_data", 32'(res_data), 32'(e[15:0]));
        check("res_flags", 32'({res_zero, res_of, res_neg}), 32'(e[18:16]));
      end
      n_seen++;
    end
  end

  always @(negedge clk) begin
    if (rst && alu_rst) alu_rst_cycles++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b1;

    // reset values
    #12;
    check("rst_alu_rst", 32'(alu_rst), 1);
    check("rst_opcode", 32'(alu_opcode), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in1", 32'(alu_in1), 0);
    check("rst_res_data", 32'(res_data), 0);
    rst = 1'b1;
    tick();
    check("alu_rst_release", 32'(alu_rst), 0);

    // ADD 5+5 with ld_a, latency 3
    push_cmd(4'b1001, 16'd5, 16'd5);
    check("add_count", 32'(fifo_count), 1);
    check("add_pre_opcode", 32'(alu_opcode), 0);
    tick();
    check("add_opcode", 32'(alu_opcode), 32'h01);
    check("add_sub", 32'(alu_sub), 0);
    check("add_ovwA", 32'(alu_ovwA), 1);
    check("add_in1", 32'(alu_in1), 5);
    check("add_in2", 32'(alu_in2), 5);
    tick();
    check("add_capture_opcode", 32'(alu_opcode), 0);
    check("add_valid_e2", 32'(res_valid), 0);
    tick();
    check("add_valid_e3", 32'(res_valid), 1);
    tick();
    check("add_valid_e4", 32'(res_valid), 0);

    // SUB 6-12
    push_cmd(4'b0010, 16'd6, 16'd12);
    tick();
    check("sub_opcode", 32'(alu_opcode), 32'h01);
    check("sub_sub", 32'(alu_sub), 1);
    check("sub_ovwA", 32'(alu_ovwA), 0);
    wait_idle();

    // MUL 20*5, held MUL_CYCLES cycles
    push_cmd(4'b0011, 16'd20, 16'd5);
    tick();
    check("mul_opcode_c1", 32'(alu_opcode), 32'h02);
    tick();
    check("mul_opcode_c2", 32'(alu_opcode), 32'h02);
    tick();
    check("mul_opcode_cap", 32'(alu_opcode), 0);
    check("mul_valid_e3", 32'(res_valid), 0);
    tick();
    check("mul_valid_e4", 32'(res_valid), 1);
    wait_idle();

    // backpressure
    res_ready = 1'b0;
    push_cmd(4'b0001, 16'd1, 16'd2);
    push_cmd(4'b0010, 16'd100, 16'd1);
    push_cmd(4'b0100, 16'hF0F0, 16'hFF00);
    push_cmd(4'b0101, 16'h00F0, 16'h0F00);
    push_cmd(4'b0011, 16'd300, 16'd300);
    check("bp_count", 32'(fifo_count), 4);
    check("bp_cmd_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(res_valid), 1);
      check("bp_hold_data", 32'(res_data), 3);
      tick();
    end
    res_ready = 1'b1;
    push_cmd(4'b0110, 16'h1234, 16'h00FF);
    wait_idle();

    // NOP, XOR, CLR, NOT
    r0 = alu_rst_cycles;
    push_cmd(4'b0000, 16'hAAAA, 16'h5555);
    push_cmd(4'b0110, 16'h00FF, 16'h0F0F);
    push_cmd(4'b1000, 16'h0000, 16'h0000);
    push_cmd(4'b0111, 16'h00FF, 16'h0F0F);
    wait_idle();
    check("clr_rst_cycles", 32'(alu_rst_cycles - r0), 2);

    // asynchronous reset in EXEC
    push_cmd(4'b0001, 16'h7FFF, 16'h0001);
    tick();
    check("abort_in_exec", 32'(alu_opcode), 32'h01);
    #2 rst = 1'b0;
    #1;
    check("abort_alu_rst", 32'(alu_rst), 1);
    check("abort_opcode", 32'(alu_opcode), 0);
    check("abort_in1", 32'(alu_in1), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_count", 32'(fifo_count), 0);
    check("abort_valid", 32'(res_valid), 0);
    sb_q.delete();
    n_exp--;
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_result", 32'(res_valid), 0);
    end
    push_cmd(4'b0001, 16'h7FFF, 16'h0001);
    wait_idle();

    check("sb_empty", 32'(sb_q.size()), 0);
    check("result_count", 32'(n_seen), 32'(n_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Command sequencer directly upstream of the ALU, with a result capture stage on its downstream side. It buffers encoded operation commands in a small FIFO and translates each into ALU control (one-hot opcode, inv, sub, ovwA, ALU reset). It holds those controls for the required number of execute cycles, then registers the ALU result and flags behind a valid/ready handshake. It replaces hand-driven per-operation stimulus with a sequenced, back-pressured interface.

Parameters:
DEPTH, 4, command FIFO depth; power of 2, minimum 2.
WIDTH, 16, operand and result width; must match the ALU.
MUL_CYCLES, 2, execute cycles held for MUL; minimum 1.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_op  in  4  [3]=ld_a, [2:0]=op: 0 NOP/CLR, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR, 7 NOT
cmd_a  in  WIDTH  operand 1
cmd_b  in  WIDTH  operand 2
alu_in1  out  WIDTH  ALU operand 1 (registered)
alu_in2  out  WIDTH  ALU operand 2 (registered)
alu_opcode  out  5  one-hot: 00001 add/sub, 00010 mul, 00100 and, 01000 or, 10000 xor
alu_inv  out  1  invert result (NOT)
alu_sub  out  1  subtract select
alu_ovwA  out  1  ALU loads accumulator A
alu_rst  out  1  ALU reset, active-high
alu_out  in  WIDTH  ALU result
alu_zero  in  1  ALU zero flag
alu_of  in  1  ALU overflow flag
alu_neg  in  1  ALU negative flag
res_valid  out  1  captured result available
res_ready  in  1  downstream accepts result
res_data  out  WIDTH  captured result
res_zero  out  1  captured zero flag
res_of  out  1  captured overflow flag
res_neg  out  1  captured negative flag
busy  out  1  FSM not in IDLE, or FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst low, asynchronous): FIFO empties; FSM goes to IDLE; alu_opcode, alu_inv, alu_sub, alu_ovwA = 0; alu_in1, alu_in2 = 0; alu_rst = 1; res_* = 0; res_valid = 0.
- alu_rst deasserts on the first rising edge after rst is released.
- Reset during EXEC, CLEAR or DONE aborts the command in flight; the pending result is lost.
- FIFO: push when cmd_valid && cmd_ready; cmd_ready = !full. Push is never accepted while full, even if a pop occurs in the same cycle. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves fifo_count unchanged.
- Decode (registered into the ALU controls on the pop edge):
  - ADD: opcode 00001, sub 0.
  - SUB: opcode 00001, sub 1.
  - MUL: opcode 00010.
  - AND: opcode 00100.
  - OR: opcode 01000.
  - XOR: opcode 10000, inv 0.
  - NOT: opcode 10000, inv 1.
  - alu_ovwA = ld_a for every non-NOP op.
- FSM states: IDLE, EXEC, CAPTURE, DONE, CLEAR.
- IDLE:
  - FIFO empty: stay in IDLE; ALU controls are NOP (opcode 0, inv/sub/ovwA 0).
  - Head is op 0 with ld_a=0 (NOP): pop and discard; produces no result; stay in IDLE.
  - Head is op 0 with ld_a=1 (CLR): pop; alu_rst=1 for exactly 2 cycles; go to CLEAR; produces no result; then return to IDLE.
  - Head is any other op: pop; drive operands and controls; go to EXEC; load the execute counter with MUL_CYCLES for MUL, otherwise 1.
- EXEC: hold all ALU controls stable; decrement the counter; on the last cycle go to CAPTURE.
- CAPTURE: controls return to NOP. On the edge leaving CAPTURE, register alu_out and the flags into res_*, set res_valid=1, go to DONE.
- DONE: res_* held stable while res_valid && !res_ready. On res_ready, clear res_valid and go to IDLE. The next pop happens no earlier than the following cycle.
- Latency: command accepted at edge 0 into an empty, idle block:
  - non-MUL: res_valid high after edge 3;
  - MUL: res_valid high after edge 2+MUL_CYCLES.
- Throughput: one non-MUL op per 4 cycles with res_ready held high.
- Result width equals WIDTH. The block performs no arithmetic; flags pass through from the ALU.

Decomposition:
- Shared package alu_pkg holds:
  - op codes OP_NOP..OP_NOT (3-bit);
  - one-hot ALU opcode constants ALU_ADD, ALU_MUL, ALU_AND, ALU_OR, ALU_XOR;
  - FSM state encoding;
  - the CLR reset-hold constant (2).
- One sub-module, cmd_fifo: a parameterised synchronous FIFO with the same clk/rst, providing push, pop, full, empty and count.

Test Plan:
- ADD: a=5, b=5, ld_a=1 -> alu_opcode 00001, alu_sub 0, alu_ovwA 1; res_data 10, zero 0, neg 0; res_valid rises 3 cycles after acceptance.
- SUB: a=6, b=12 -> alu_sub 1; res_data 0xFFFA, neg 1, zero 0.
- MUL with MUL_CYCLES=2: a=20, b=5 -> alu_opcode 00010 held 2 cycles; res_data 100; res_valid 4 cycles after acceptance.
- Backpressure: res_ready low, push 6 commands -> after the first is popped, the FIFO fills to fifo_count=4 and cmd_ready drops; res_data stays stable until res_ready is raised; all results emerge in order.
- CLR between XOR(0x00FF, 0x0F0F) and NOT of the same operands -> XOR result 0x0FF0; alu_rst high exactly 2 cycles; no result for CLR; NOT result 0xF00F.
- Async reset asserted mid-EXEC of ADD(0x7FFF, 1) -> outputs immediately at reset values, alu_rst=1, no result emitted. After release, re-issuing ADD(0x7FFF, 1) gives res_data 0x8000, of=1, neg=1.
